// File: rtl/knn_pkg.sv
// ============================================================================
// Module      : knn_pkg
// Description : Shared label width, class count, vote FSM encoding and a
//               ceil-log2 helper used to size the vote counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package knn_pkg;

    localparam int unsigned KNN_TYPE_W    = 3;
    localparam int unsigned KNN_N_CLASSES = 2 ** KNN_TYPE_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COUNT  = 3'd2,
        ST_SELECT = 3'd3,
        ST_OUT    = 3'd4
    } knn_state_t;

    function automatic int unsigned knn_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/knn_class_counter.sv
// ============================================================================
// Module      : knn_class_counter
// Description : Per-class vote counters with the index of each class's first
//               (nearest) occurrence. Class 0 means "no class" and never counts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module knn_class_counter
    import knn_pkg::*;
#(
    parameter int unsigned TYPE_W = KNN_TYPE_W,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 inc,
    input  logic [TYPE_W-1:0]                    label,
    input  logic [CNT_W-1:0]                     index,
    output logic [(2**TYPE_W)-1:0][CNT_W-1:0]    cnt,
    output logic [(2**TYPE_W)-1:0][CNT_W-1:0]    first
);

    localparam int unsigned c_n_classes = 2 ** TYPE_W;

    generate
        for (genvar c = 0; c < c_n_classes; c++) begin : g_class
            if (c == 0) begin : g_none
                assign cnt[c]   = '0;
                assign first[c] = '0;
            end else begin : g_slot
                logic [CNT_W-1:0] r_cnt;
                logic [CNT_W-1:0] r_first;
                logic             w_hit;

                assign w_hit = inc && (label == TYPE_W'(c));

                always_ff @(posedge clk) begin
                    if (rst || clear) begin
                        r_cnt   <= '0;
                        r_first <= '0;
                    end else if (w_hit) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == '0) begin
                            r_first <= index;
                        end
                    end
                end

                assign cnt[c]   = r_cnt;
                assign first[c] = r_first;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/knn_vote.sv
// ============================================================================
// Module      : knn_vote
// Description : Majority vote over the K nearest sorted labels; nearer
//               neighbour wins ties. Define KNN_VOTE_COUNT_EN to add the
//               winner_votes output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module knn_vote
    import knn_pkg::*;
#(
    parameter int unsigned N      = 100,
    parameter int unsigned K      = 5,
    parameter int unsigned TYPE_W = KNN_TYPE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_sort,
    input  logic [N*TYPE_W-1:0]   type_array_sorted,
    output logic [TYPE_W-1:0]     class_out,
    output logic                  valid_class,
    output logic                  busy
`ifdef KNN_VOTE_COUNT_EN
    ,
    output logic [knn_clog2(K+1)-1:0] winner_votes
`endif
);

    localparam int unsigned c_n_classes = 2 ** TYPE_W;
    localparam int unsigned c_cnt_w     = knn_clog2(K + 1);

    knn_state_t                               r_state;
    logic                                     r_valid_sort_q;
    logic [K-1:0][TYPE_W-1:0]                 r_labels;
    logic [c_cnt_w-1:0]                       r_index;
    logic [TYPE_W-1:0]                        r_scan;
    logic [TYPE_W-1:0]                        r_best;
    logic [TYPE_W-1:0]                        r_class;
    logic                                     r_valid;
    logic [c_n_classes-1:0][c_cnt_w-1:0]      w_cnt;
    logic [c_n_classes-1:0][c_cnt_w-1:0]      w_first;
    logic                                     w_start;
    logic                                     w_take;
    logic [TYPE_W-1:0]                        w_best_next;

    generate
        if (K < N) begin : g_unused_tail
            logic w_unused_tail;
            assign w_unused_tail = ^type_array_sorted[N*TYPE_W-1:K*TYPE_W];
        end
    endgenerate

    assign w_start = valid_sort & ~r_valid_sort_q;

    knn_class_counter #(
        .TYPE_W (TYPE_W),
        .CNT_W  (c_cnt_w)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == ST_LOAD),
        .inc    (r_state == ST_COUNT),
        .label  (r_labels[0]),
        .index  (r_index),
        .cnt    (w_cnt),
        .first  (w_first)
    );

    // Class 0 is never a candidate; equal nonzero counts go to the earlier hit.
    always_comb begin
        w_take = 1'b0;
        if (r_scan != '0) begin
            if (w_cnt[r_scan] > w_cnt[r_best]) begin
                w_take = 1'b1;
            end else if ((w_cnt[r_scan] == w_cnt[r_best]) && (w_cnt[r_scan] != '0)
                         && (w_first[r_scan] < w_first[r_best])) begin
                w_take = 1'b1;
            end
        end
        w_best_next = w_take ? r_scan : r_best;
    end

`ifdef KNN_VOTE_COUNT_EN
    logic [c_cnt_w-1:0] r_votes;
    assign winner_votes = r_votes;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_valid_sort_q <= 1'b0;
            r_labels       <= '0;
            r_index        <= '0;
            r_scan         <= '0;
            r_best         <= '0;
            r_class        <= '0;
            r_valid        <= 1'b0;
`ifdef KNN_VOTE_COUNT_EN
            r_votes        <= '0;
`endif
        end else begin
            r_valid_sort_q <= valid_sort;
            r_valid        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_labels <= type_array_sorted[K*TYPE_W-1:0];
                    r_index  <= '0;
                    r_scan   <= '0;
                    r_best   <= '0;
                    r_state  <= ST_COUNT;
                end
                ST_COUNT: begin
                    r_labels <= r_labels >> TYPE_W;
                    r_index  <= r_index + c_cnt_w'(1);
                    if (r_index == c_cnt_w'(K - 1)) begin
                        r_state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    r_best <= w_best_next;
                    r_scan <= r_scan + TYPE_W'(1);
                    if (r_scan == '1) begin
                        r_class <= w_best_next;
                        r_valid <= 1'b1;
`ifdef KNN_VOTE_COUNT_EN
                        r_votes <= w_cnt[w_best_next];
`endif
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign class_out   = r_class;
    assign valid_class = r_valid;
    assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_knn_vote.sv
// ============================================================================
// Module      : tb_knn_vote
// Description : Self-checking bench for knn_vote: vector table, scoreboard of
//               expected results, and hand sequences for retrigger and abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_knn_vote;
    import knn_pkg::*;

    localparam int N      = 100;
    localparam int K      = 5;
    localparam int TYPE_W = 3;
    localparam int CW     = knn_clog2(K + 1);
    localparam int LAT    = 1 + K + (2 ** TYPE_W) + 1;
    localparam int NVEC   = 9;

    typedef struct packed {
        logic [TYPE_W-1:0] cls;
        logic [CW-1:0]     votes;
    } exp_t;

    typedef struct packed {
        logic [K*TYPE_W-1:0] lab;
        logic [TYPE_W-1:0]   cls;
        logic [CW-1:0]       votes;
    } vec_t;

    logic                clk;
    logic                rst;
    logic                valid_sort;
    logic [N*TYPE_W-1:0] type_array_sorted;
    logic [TYPE_W-1:0]   class_out;
    logic                valid_class;
    logic                busy;
`ifdef KNN_VOTE_COUNT_EN
    logic [CW-1:0]       winner_votes;
`endif

    int   n_checks;
    int   n_fail;
    int   pulses;
    logic prev_vc;
    exp_t mon_e;
    exp_t exp_q[$];
    vec_t vecs[NVEC];

    knn_vote #(.N(N), .K(K), .TYPE_W(TYPE_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_sort        (valid_sort),
        .type_array_sorted (type_array_sorted),
        .class_out         (class_out),
        .valid_class       (valid_class),
        .busy              (busy)
`ifdef KNN_VOTE_COUNT_EN
        ,
        .winner_votes      (winner_votes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [K*TYPE_W-1:0] lab5(input int a, input int b, input int c,
                                                 input int d, input int e);
        return {TYPE_W'(e), TYPE_W'(d), TYPE_W'(c), TYPE_W'(b), TYPE_W'(a)};
    endfunction

    // Majority by counting each label's occurrences; scanning nearest-first
    // with a strict comparison gives ties to the earlier label.
    function automatic exp_t ref_model(input logic [N*TYPE_W-1:0] arr);
        exp_t              r;
        int                best;
        int                best_n;
        int                n;
        logic [TYPE_W-1:0] li;
        logic [TYPE_W-1:0] lj;
        best   = 0;
        best_n = 0;
        for (int i = 0; i < K; i++) begin
            li = arr[i*TYPE_W +: TYPE_W];
            if (li != 0) begin
                n = 0;
                for (int j = 0; j < K; j++) begin
                    lj = arr[j*TYPE_W +: TYPE_W];
                    if (lj == li) n++;
                end
                if (n > best_n) begin
                    best   = int'(li);
                    best_n = n;
                end
            end
        end
        r.cls   = TYPE_W'(best);
        r.votes = CW'(best_n);
        return r;
    endfunction

    always @(negedge clk) begin
        if (valid_class) begin
            pulses++;
            check("pulse_width", {31'd0, prev_vc}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid_class: got class %0d, expected no result", class_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("class_out", class_out, mon_e.cls);
`ifdef KNN_VOTE_COUNT_EN
                check("winner_votes", winner_votes, mon_e.votes);
`endif
            end
        end
        prev_vc = valid_class;
    end

    task automatic run_vote(input logic [N*TYPE_W-1:0] arr, input exp_t e, input string tag);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        type_array_sorted = arr;
        valid_sort        = 1'b1;
        exp_q.push_back(e);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) valid_sort = 1'b0;
            if (i == 3) type_array_sorted = {N*TYPE_W{1'b1}};
            if (i == 5) check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
            if (valid_class) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, LAT);
        @(posedge clk); #1;
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*TYPE_W-1:0] arr;
        exp_t                e;
        int                  base;

        n_checks = 0;
        n_fail   = 0;
        pulses   = 0;
        prev_vc  = 1'b0;

        vecs[0] = '{lab: lab5(2, 2, 3, 1, 2), cls: 3'd2, votes: 3'd3};
        vecs[1] = '{lab: lab5(3, 1, 1, 3, 5), cls: 3'd3, votes: 3'd2};
        vecs[2] = '{lab: lab5(0, 0, 0, 0, 0), cls: 3'd0, votes: 3'd0};
        vecs[3] = '{lab: lab5(4, 4, 4, 1, 1), cls: 3'd4, votes: 3'd3};
        vecs[4] = '{lab: lab5(1, 2, 3, 4, 5), cls: 3'd1, votes: 3'd1};
        vecs[5] = '{lab: lab5(0, 0, 7, 7, 6), cls: 3'd7, votes: 3'd2};
        vecs[6] = '{lab: lab5(5, 6, 6, 5, 0), cls: 3'd5, votes: 3'd2};
        vecs[7] = '{lab: lab5(0, 3, 0, 0, 0), cls: 3'd3, votes: 3'd1};
        vecs[8] = '{lab: lab5(6, 6, 6, 6, 6), cls: 3'd6, votes: 3'd5};

        rst               = 1'b1;
        valid_sort        = 1'b0;
        type_array_sorted = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_class_out", class_out, 32'd0);
        check("reset_valid_class", {31'd0, valid_class}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
`ifdef KNN_VOTE_COUNT_EN
        check("reset_winner_votes", winner_votes, 32'd0);
`endif

        // Entries beyond K are label 7 so any leak past K changes the winner.
        for (int v = 0; v < NVEC; v++) begin
            arr = {N*TYPE_W{1'b1}};
            arr[K*TYPE_W-1:0] = vecs[v].lab;
            e.cls   = vecs[v].cls;
            e.votes = vecs[v].votes;
            run_vote(arr, e, $sformatf("vec%0d", v));
        end

        // Edge while busy and a level held high must yield a single result.
        base = pulses;
        arr = {N*TYPE_W{1'b1}};
        arr[K*TYPE_W-1:0] = lab5(1, 2, 2, 0, 1);
        @(posedge clk); #1;
        type_array_sorted = arr;
        valid_sort        = 1'b1;
        e.cls   = 3'd1;
        e.votes = 3'd2;
        exp_q.push_back(e);
        repeat (3) @(posedge clk);
        #1 valid_sort = 1'b0;
        repeat (2) @(posedge clk);
        #1 valid_sort = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("held_high_pulses", pulses - base, 32'd1);
        check("held_high_busy", {31'd0, busy}, 32'd0);
        valid_sort = 1'b0;
        arr[K*TYPE_W-1:0] = lab5(7, 5, 5, 7, 5);
        e.cls   = 3'd5;
        e.votes = 3'd3;
        run_vote(arr, e, "after_held");

        // Reset six cycles into a vote aborts it without a result.
        base = pulses;
        arr[K*TYPE_W-1:0] = lab5(2, 2, 2, 2, 2);
        @(posedge clk); #1;
        type_array_sorted = arr;
        valid_sort        = 1'b1;
        @(posedge clk); #1;
        valid_sort = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_class_out", class_out, 32'd0);
        check("abort_valid_class", {31'd0, valid_class}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_pulse", pulses - base, 32'd0);
        arr[K*TYPE_W-1:0] = lab5(4, 4, 4, 1, 1);
        e.cls   = 3'd4;
        e.votes = 3'd3;
        run_vote(arr, e, "post_abort");

        // Back-to-back sorts with reference-model expectations.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                arr[i*TYPE_W +: TYPE_W] = TYPE_W'($urandom_range(0, (i < K) ? 3 : 7));
            end
            e = ref_model(arr);
            run_vote(arr, e, $sformatf("b2b%0d", r));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/knn_vote.md
Name: knn_vote

Overview:
- Consumer of the distance-sort result in the KNN system.
- Waits for valid_sort, captures the class labels of the K nearest entries (indices 0..K-1 of the ascending-sorted type array), and counts votes per class.
- Outputs the majority class with a one-cycle valid_class strobe.
- Sits directly downstream of distance_sort and drives the system classification result.

Parameters:
- N, 100, number of entries in the sorted array (must match distance_sort).
- K, 5, number of nearest neighbours voting; 1 <= K <= N.
- TYPE_W, 3, class label width; classes 0..2^TYPE_W-1, class 0 = "no class".

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_sort  in  1  level from distance_sort; a rising edge starts a vote.
- type_array_sorted  in  N*TYPE_W  flattened sorted labels; entry i at bits [i*TYPE_W +: TYPE_W], entry 0 nearest.
- class_out  out  TYPE_W  winning class, held until the next result.
- valid_class  out  1  one-cycle pulse when class_out is updated.
- busy  out  1  high from LOAD through OUT.

Behaviour:
- Reset: rst sampled high forces the following, regardless of state; rst mid-vote aborts with no valid_class pulse.
  - state=IDLE; class_out=0, valid_class=0, busy=0.
  - all vote counters and first-index registers cleared.
  - valid_sort history register = 0.
- Start: edge detector on a registered valid_sort_q. Start = valid_sort & ~valid_sort_q, sampled in IDLE only.
  - Edges while busy are ignored.
  - valid_sort held high does not retrigger.
- FSM, one state per cycle unless noted:
  - IDLE: wait for start → LOAD.
  - LOAD: capture labels 0..K-1 into a local K-entry shift register; clear counters; index=0 → COUNT.
  - COUNT (K cycles): for label L = entry[index], if L != 0, increment cnt[L]. If cnt[L] was 0, record first[L]=index. index++; after index K-1 → SELECT.
  - SELECT (2^TYPE_W cycles): scan classes c=1..2^TYPE_W-1 (cycle for c=0 is idle-scan) keeping best.
    - c replaces best if cnt[c] > cnt[best].
    - On equal nonzero counts, c replaces best if first[c] < first[best] (nearer neighbour wins ties).
    - best initialised to 0 with count 0 → SELECT done → OUT.
  - OUT: class_out=best, valid_class=1 for this cycle only → IDLE.
- Latency: valid_class is high exactly 1+K+2^TYPE_W+1 cycles after the start edge (15 for defaults), i.e. LOAD(1)+COUNT(K)+SELECT(2^TYPE_W)+OUT.
- Counter width: clog2(K+1) bits; no overflow possible.
- All K labels = 0 → class_out=0, valid_class still pulses.
- Input array sampled only in LOAD; later changes do not affect the result.
- busy=1 in LOAD, COUNT, SELECT, OUT.

Optional Feature:
- Macro: KNN_VOTE_COUNT_EN.
- Defined: extra output winner_votes (width clog2(K+1)) = cnt[best], updated with class_out in OUT; reset value 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package knn_pkg holds:
  - TYPE_W default and N_CLASSES = 2^TYPE_W.
  - FSM state encoding (IDLE, LOAD, COUNT, SELECT, OUT).
  - clog2 function for counter widths.
- One sub-module, knn_class_counter: bank of N_CLASSES vote counters plus first-index registers.
  - Inputs: clear, inc enable, label, index.
  - Outputs: cnt/first read by class select.
  - The top-level keeps the FSM, edge detect and argmax.

Test Plan:
- Sorted labels [2,2,3,1,2,...] (K=5) → class_out=2 at cycle 15 after valid_sort rises; valid_class high 1 cycle; winner_votes=3 with KNN_VOTE_COUNT_EN.
- Tie: labels [3,1,1,3,5] → cnt[1]=cnt[3]=2, first[3]=0 < first[1]=1 → class_out=3.
- All labels 0 → class_out=0, valid_class pulses once at cycle 15.
- valid_sort held high 40 cycles, second rising edge while busy → exactly one valid_class; new edge after IDLE → second result.
- rst asserted 6 cycles into a vote → no valid_class, class_out=0, busy=0 next cycle; subsequent vote with labels [4,4,4,1,1] → class_out=4.
- Three back-to-back sorts (the distance_sort test ranges 100/200/1000) → three results matching a reference model computing the majority over the first K labels.
